// File: rtl/branch_resolve.sv
// branch_resolve: in-order FIFO of branch predictions, resolved oldest-first with predictor update and redirect.
// Optional counters enabled by defining BRANCH_RESOLVE_STATS_EN.
module branch_resolve #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic [1:0]  pred_type,
  input  logic [3:0]  pred_bhr,
  output logic        pred_ready,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        res_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        upd_en,
  output logic [31:0] upd_pc,
  output logic        upd_taken,
  output logic [31:0] upd_target,
  output logic [1:0]  upd_type,
  output logic [3:0]  upd_bhr,
  output logic [4:0]  occupancy,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic {NORMAL, RECOVER} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  typ;
    logic [3:0]  bhr;
  } rec_t;
  rec_t          mem_q [DEPTH];
  rec_t          head;
  state_t        state_q;
  logic [AW-1:0] rd_q, wr_q;
  logic [4:0]    cnt_q;
  logic          upd_en_q, redir_q, upd_taken_q;
  logic [31:0]   redir_pc_q, upd_pc_q, upd_target_q;
  logic [1:0]    upd_type_q;
  logic [3:0]    upd_bhr_q;
  logic          full, empty, push, pop, mis;
  assign head       = mem_q[rd_q];
  assign full       = cnt_q == 5'(DEPTH);
  assign empty      = cnt_q == 5'd0;
  assign pred_ready = (state_q == NORMAL) & ~full;
  assign res_ready  = (state_q == NORMAL) & ~empty;
  assign push       = pred_valid & pred_ready;
  assign pop        = res_valid & res_ready;
  assign mis        = pop & ((res_taken != head.taken) | (res_taken & (res_target != head.target)));
  assign occupancy      = cnt_q;
  assign upd_en         = upd_en_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign upd_target     = upd_target_q;
  assign upd_type       = upd_type_q;
  assign upd_bhr        = upd_bhr_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = redir_pc_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {pred_pc, pred_taken, pred_target, pred_type, pred_bhr};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q      <= NORMAL;
      rd_q         <= '0;
      wr_q         <= '0;
      cnt_q        <= '0;
      upd_en_q     <= 1'b0;
      redir_q      <= 1'b0;
      redir_pc_q   <= '0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      upd_target_q <= '0;
      upd_type_q   <= '0;
      upd_bhr_q    <= '0;
    end else begin
      upd_en_q <= pop;
      redir_q  <= mis;
      if (pop) begin
        upd_pc_q     <= head.pc;
        upd_type_q   <= head.typ;
        upd_bhr_q    <= head.bhr;
        upd_taken_q  <= res_taken;
        upd_target_q <= res_target;
      end
      if (mis) redir_pc_q <= res_taken ? res_target : head.pc + 32'd4;
      // A mispredict flushes everything younger, including a same-cycle push.
      if (mis) begin
        state_q <= RECOVER;
        rd_q    <= '0;
        wr_q    <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= NORMAL;
        if (push) wr_q <= wr_q + 1'b1;
        if (pop) rd_q <= rd_q + 1'b1;
        cnt_q <= cnt_q + 5'(push) - 5'(pop);
      end
    end
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] br_q, mis_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      if (pop) br_q <= br_q + 32'd1;
      if (mis) mis_q <= mis_q + 32'd1;
    end
  assign stat_branches    = br_q;
  assign stat_mispredicts = mis_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and random stimulus against a queue-based reference model.
module tb_branch_resolve;
  localparam int DEPTH = 8;
  logic clk = 1'b0, resetn = 1'b0;
  logic pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0] pred_pc = '0, pred_target = '0, res_target = '0;
  logic [1:0] pred_type = '0;
  logic [3:0] pred_bhr = '0;
  logic pred_ready, res_ready, redirect_valid, upd_en, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target, stat_branches, stat_mispredicts;
  logic [1:0] upd_type;
  logic [3:0] upd_bhr;
  logic [4:0] occupancy;
  branch_resolve #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_type(pred_type), .pred_bhr(pred_bhr),
    .pred_ready(pred_ready), .res_valid(res_valid), .res_taken(res_taken),
    .res_target(res_target), .res_ready(res_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_type(upd_type), .upd_bhr(upd_bhr), .occupancy(occupancy),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc;
    logic        t;
    logic [31:0] tgt;
    logic [1:0]  ty;
    logic [3:0]  b;
  } rec_t;
  rec_t q[$];
  bit recover = 0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_br = 0, m_mis = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    pred_valid = 1'b0;
    res_valid = 1'b0;
    #1;
    check("rst_occ", occupancy, 0);
    check("rst_upd_en", upd_en, 0);
    check("rst_redir", redirect_valid, 0);
    check("rst_redir_pc", redirect_pc, 0);
    check("rst_upd_pc", upd_pc, 0);
    check("rst_upd_tgt", upd_target, 0);
    check("rst_upd_misc", {upd_taken, upd_type, upd_bhr}, 0);
    check("rst_stat_br", stat_branches, 0);
    check("rst_stat_mis", stat_mispredicts, 0);
    q.delete();
    recover = 0;
    m_br = 0;
    m_mis = 0;
    @(negedge clk);
    resetn = 1'b1;
  endtask
  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptgt,
                      input logic [1:0] pty, input logic [3:0] pb,
                      input logic rv, input logic rt, input logic [31:0] rtgt);
    bit e_pr, e_rr, e_upd, e_red, mis;
    rec_t h;
    logic [31:0] e_rpc;
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptgt;
    pred_type = pty; pred_bhr = pb; res_valid = rv; res_taken = rt; res_target = rtgt;
    #1;
    e_pr = !recover && q.size() < DEPTH;
    e_rr = !recover && q.size() > 0;
    check("pred_ready", pred_ready, e_pr);
    check("res_ready", res_ready, e_rr);
    @(posedge clk);
    e_upd = rv && e_rr;
    e_red = 0;
    e_rpc = 0;
    if (e_upd) begin
      h = q.pop_front();
      mis = (rt != h.t) || (rt && rtgt != h.tgt);
      e_red = mis;
      e_rpc = rt ? rtgt : h.pc + 32'd4;
`ifdef BRANCH_RESOLVE_STATS_EN
      m_br++;
      if (mis) m_mis++;
`endif
    end
    if (pv && e_pr) q.push_back('{ppc, pt, ptgt, pty, pb});
    if (e_red) q.delete();
    recover = e_red;
    #1;
    check("upd_en", upd_en, e_upd);
    check("redirect_valid", redirect_valid, e_red);
    check("occupancy", occupancy, q.size());
    if (e_upd) begin
      check("upd_pc", upd_pc, h.pc);
      check("upd_target", upd_target, rtgt);
      check("upd_misc", {upd_taken, upd_type, upd_bhr}, {rt, h.ty, h.b});
    end
    if (e_red) check("redirect_pc", redirect_pc, e_rpc);
    check("stat_branches", stat_branches, m_br);
    check("stat_mispredicts", stat_mispredicts, m_mis);
    @(negedge clk);
  endtask
  task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    step(1, pc, t, tgt, 2'b00, 4'h5, 0, 0, 0);
  endtask
  task automatic resolve(input logic t, input logic [31:0] tgt);
    step(0, 0, 0, 0, 0, 0, 1, t, tgt);
  endtask
  initial begin
    do_reset();
    // taken with wrong target: redirect to actual target
    push(32'h120, 1, 32'h2F0);
    resolve(1, 32'h300);
    check("d_tgt_redir_pc", redirect_pc, 32'h300);
`ifdef BRANCH_RESOLVE_STATS_EN
    check("d_tgt_stat_mis", stat_mispredicts, 1);
`else
    check("d_tgt_stat_mis", stat_mispredicts, 0);
`endif
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // correct prediction
    push(32'h100, 1, 32'h200);
    resolve(1, 32'h200);
    check("d_ok_upd_pc", upd_pc, 32'h100);
    check("d_ok_redir", redirect_valid, 0);
    // not-taken mispredict flushes younger records and a same-cycle push
    push(32'h104, 1, 32'h500);
    push(32'h110, 0, 32'h0);
    push(32'h114, 1, 32'h700);
    step(1, 32'h118, 0, 0, 0, 0, 1, 0, 0);
    check("d_nt_redir_pc", redirect_pc, 32'h108);
    step(1, 32'h11C, 0, 0, 0, 0, 0, 0, 0);
    check("d_nt_occ", occupancy, 0);
    // fill to full, then simultaneous push+pop
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i) * 4, 0, 0);
    check("d_full_occ", occupancy, DEPTH);
    check("d_full_pready", pred_ready, 0);
    step(1, 32'h2000, 0, 0, 0, 0, 1, 0, 0);
    check("d_full_pop_occ", occupancy, DEPTH - 1);
    while (q.size() > 0) resolve(0, 0);
    // resolution while empty is ignored
    resolve(1, 32'h40);
    check("d_empty_upd", upd_en, 0);
    // reset with records queued
    push(32'h300, 0, 0);
    push(32'h304, 0, 0);
    push(32'h308, 0, 0);
    do_reset();
    // reset during recovery
    push(32'h400, 1, 32'h800);
    push(32'h404, 0, 0);
    resolve(0, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic rt;
      logic [31:0] rtgt;
      rt = $urandom_range(0, 1);
      rtgt = {$urandom_range(0, 15), 4'h0};
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt = q[0].t;
        rtgt = q[0].tgt;
      end
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1), {$urandom_range(0, 15), 4'h0},
           2'($urandom), 4'($urandom), $urandom_range(0, 2) != 0, rt, rtgt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
